// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM states, default sizing and byte-lane helpers for data_mem_arbiter
package data_mem_pkg;
  typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, BYTE2, DONE} state_t;
  localparam int MEM_BYTES_DEF = 128;
  localparam int PROT_LIMIT_DEF = 10;
  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  function automatic logic [1:0] lane_of(state_t s);
    return s == BYTE1 ? LANE1 : s == BYTE2 ? LANE2 : LANE0;
  endfunction
  function automatic logic [7:0] word_byte(logic [23:0] w, logic [1:0] lane);
    return lane == LANE0 ? w[23:16] : lane == LANE1 ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the pointer names the last winner
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_ptr_next
);
  assign o_gnt[0]   = i_en && i_req[0] && (!i_req[1] || i_ptr);
  assign o_gnt[1]   = i_en && i_req[1] && (!i_req[0] || !i_ptr);
  assign o_ptr_next = |o_gnt ? o_gnt[1] : i_ptr;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates two word requesters onto a byte-wide memory with write remap and range check
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int MEM_BYTES  = MEM_BYTES_DEF,
  parameter int PROT_LIMIT = PROT_LIMIT_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_req0,
  input  logic                         i_req1,
  input  logic                         i_write0,
  input  logic                         i_write1,
  input  logic [23:0]                  i_addr0,
  input  logic [23:0]                  i_addr1,
  input  logic [23:0]                  i_wdata0,
  input  logic [23:0]                  i_wdata1,
  output logic                         o_done0,
  output logic                         o_done1,
  output logic [23:0]                  o_rdata,
  output logic                         o_err,
  output logic                         o_busy,
  output logic [$clog2(MEM_BYTES)-1:0] o_mem_addr,
  output logic [7:0]                   o_mem_wdata,
  output logic                         o_mem_we,
  input  logic [7:0]                   i_mem_rdata
);
  localparam int AW = $clog2(MEM_BYTES);
  state_t          r_state, w_next;
  logic            r_ptr, w_ptr_next;
  logic [1:0]      w_gnt;
  logic            w_take, w_sel, w_write_in, w_oob;
  logic [23:0]     w_addr_in, w_wdata_in, w_eff_in;
  logic            r_port, r_write;
  logic [AW-1:0]   r_eff;
  logic [23:0]     r_wdata;
  logic [15:0]     r_buf;
  logic            w_cur_port, w_cur_write, w_is_byte;
  logic [AW-1:0]   w_cur_eff;
  logic [23:0]     w_cur_wdata;
  logic [1:0]      w_lane;
  logic            r_done0, r_done1, r_err, r_busy, r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [7:0]      r_mem_wdata;
  logic [23:0]     r_rdata;

  rr_arbiter2 u_rr (
    .i_req      ({i_req1, i_req0}),
    .i_ptr      (r_ptr),
    .i_en       (r_state == IDLE),
    .o_gnt      (w_gnt),
    .o_ptr_next (w_ptr_next)
  );

  assign w_take     = |w_gnt;
  assign w_sel      = w_gnt[1];
  assign w_write_in = w_sel ? i_write1 : i_write0;
  assign w_addr_in  = w_sel ? i_addr1  : i_addr0;
  assign w_wdata_in = w_sel ? i_wdata1 : i_wdata0;
  assign w_eff_in   = (w_write_in && w_addr_in < 24'(PROT_LIMIT)) ? w_addr_in + 24'(PROT_LIMIT) : w_addr_in;
  assign w_oob      = ({1'b0, w_eff_in} + 25'd2) >= 25'(MEM_BYTES);

  // The transaction being set up this edge: fresh request in IDLE, latched one otherwise
  assign w_cur_port  = w_take ? w_sel : r_port;
  assign w_cur_write = w_take ? w_write_in : r_write;
  assign w_cur_eff   = w_take ? w_eff_in[AW-1:0] : r_eff;
  assign w_cur_wdata = w_take ? w_wdata_in : r_wdata;
  assign w_is_byte   = w_next == BYTE0 || w_next == BYTE1 || w_next == BYTE2;
  assign w_lane      = lane_of(w_next);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b1;
    end else begin
      r_state <= w_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Next-state: out-of-range requests skip the byte phases entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_take ? (w_oob ? DONE : BYTE0) : IDLE;
      BYTE0:   w_next = BYTE1;
      BYTE1:   w_next = BYTE2;
      BYTE2:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Registered (Moore) outputs derived from the state being entered, plus read assembly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_port      <= 1'b0;
      r_write     <= 1'b0;
      r_eff       <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_take) begin
        r_port  <= w_sel;
        r_write <= w_write_in;
        r_eff   <= w_eff_in[AW-1:0];
        r_wdata <= w_wdata_in;
      end
      r_busy   <= w_next != IDLE;
      r_mem_we <= w_is_byte && w_cur_write;
      if (w_is_byte) begin
        r_mem_addr  <= w_cur_eff + AW'(w_lane);
        r_mem_wdata <= word_byte(w_cur_wdata, w_lane);
      end
      r_done0 <= w_next == DONE && !w_cur_port;
      r_done1 <= w_next == DONE && w_cur_port;
      r_err   <= r_state == IDLE && w_next == DONE;
      if (!r_write && r_state == BYTE0) r_buf[15:8] <= i_mem_rdata;
      if (!r_write && r_state == BYTE1) r_buf[7:0] <= i_mem_rdata;
      if (!r_write && r_state == BYTE2) r_rdata <= {r_buf, i_mem_rdata};
    end
  end

  assign o_done0     = r_done0;
  assign o_done1     = r_done1;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_rdata     = r_rdata;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench with a byte memory model and a reference memory
module tb_data_mem_arbiter;
  typedef struct {
    logic        port;
    logic        err;
    logic [23:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        done0, done1, err, busy, mem_we;
  logic [23:0] rdata;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem [128];
  logic [7:0]  ref_mem [128];
  logic        load = 1'b1;
  logic [23:0] last_rdata = '0;
  exp_t        sb[$];
  exp_t        e;
  int          n_vec = 0, n_err = 0, cyc = 0, t0 = 0, k = 0;
  int          t[4] = '{0, 0, 0, 0};
  logic        oob;

  data_mem_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req0      (req0),
    .i_req1      (req1),
    .i_write0    (write0),
    .i_write1    (write1),
    .i_addr0     (addr0),
    .i_addr1     (addr1),
    .i_wdata0    (wdata0),
    .i_wdata1    (wdata1),
    .o_done0     (done0),
    .o_done1     (done1),
    .o_rdata     (rdata),
    .o_err       (err),
    .o_busy      (busy),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(int i);
    return 8'(i * 37 + 5);
  endfunction

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (load) for (int i = 0; i < 128; i++) mem[i] <= pat(i);
    else if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: remap, range check, big-endian byte order
  task automatic model_push(input logic port, input logic wr, input logic [23:0] addr,
                            input logic [23:0] data, output logic o);
    logic [24:0] eff;
    exp_t x;
    eff = (wr && addr < 24'd10) ? {1'b0, addr} + 25'd10 : {1'b0, addr};
    o = eff + 25'd2 >= 25'd128;
    if (!o && wr) begin
      ref_mem[eff[6:0]]        = data[23:16];
      ref_mem[eff[6:0] + 7'd1] = data[15:8];
      ref_mem[eff[6:0] + 7'd2] = data[7:0];
    end else if (!o)
      last_rdata = {ref_mem[eff[6:0]], ref_mem[eff[6:0] + 7'd1], ref_mem[eff[6:0] + 7'd2]};
    x.port = port;
    x.err = o;
    x.rdata = last_rdata;
    sb.push_back(x);
  endtask

  task automatic xact(input logic port, input logic wr, input logic [23:0] addr, input logic [23:0] data);
    logic o;
    int n;
    model_push(port, wr, addr, data, o);
    @(posedge clk); #1;
    if (port) begin write1 = wr; addr1 = addr; wdata1 = data; req1 = 1'b1; end
    else begin write0 = wr; addr0 = addr; wdata0 = data; req0 = 1'b1; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(port ? done1 : done0) && n < 20);
    chk("latency", n, o ? 1 : 4);
    if (o) chk("err_no_we", mem_we, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Scoreboard: every Done pops one expected result
  always @(negedge clk)
    if (done0 || done1) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_port", {done1, done0}, e.port ? 2'b10 : 2'b01);
        chk("err", err, e.err);
        chk("rdata", rdata, e.rdata);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    #1 load = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_err", err, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    // Both requesters held from reset: alternating grants 5 cycles apart
    model_push(0, 0, 24'd40, 0, oob);
    model_push(1, 0, 24'd50, 0, oob);
    model_push(0, 0, 24'd40, 0, oob);
    model_push(1, 0, 24'd50, 0, oob);
    addr0 = 24'd40; addr1 = 24'd50; req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(posedge clk); #1;
      if (done0 || done1) begin t[k] = cyc; k++; end
      if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("rr_count", k, 4);
    chk("rr_first_lat", t[0] - t0, 4);
    for (int i = 0; i < 3; i++) chk("rr_gap", t[i + 1] - t[i], 5);
    // Directed word traffic including remap and range boundaries
    xact(0, 1, 24'd20, 24'hA1B2C3);
    xact(1, 0, 24'd20, 0);
    xact(0, 1, 24'd3, 24'h112233);
    xact(0, 0, 24'd3, 0);
    xact(1, 0, 24'd13, 0);
    xact(1, 0, 24'd126, 0);
    xact(0, 1, 24'hFFFFFF, 24'h445566);
    xact(1, 1, 24'd9, 24'h778899);
    xact(1, 0, 24'd19, 0);
    xact(0, 1, 24'd125, 24'hCAFE01);
    xact(1, 0, 24'd125, 0);
    xact(0, 1, 24'd126, 24'h0BAD00);
    xact(0, 1, 24'd10, 24'h5A5A5A);
    xact(1, 0, 24'd10, 0);
    // Reset during BYTE1 of a write: byte 0 lands, the rest does not
    @(posedge clk); #1;
    addr0 = 24'd60; wdata0 = 24'hDEADBE; write0 = 1'b1; req0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_rdata", rdata, 0);
    ref_mem[60] = 8'hDE;
    last_rdata = '0;
    req0 = 1'b0; write0 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_push(0, 0, 24'd60, 0, oob);
    model_push(1, 0, 24'd61, 0, oob);
    @(posedge clk); #1;
    addr0 = 24'd60; addr1 = 24'd61; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 30 && (req0 || req1); i++) begin
      @(posedge clk); #1;
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
    end
    chk("pair_timeout", {req1, req0}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    for (int i = 0; i < 128; i++) chk("mem", mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Sequencing front-end for the byte-wide data memory of the 24-bit CPU. Arbitrates between two 24-bit requesters (port 0: CPU load/store unit, port 1: debug/program loader) with 2-way round-robin. Splits each word access into three big-endian byte accesses on the memory's byte port. Applies the protected-region write remap and range checking in one place, so requesters never drive memory directly.

## Interface
- `MEM_BYTES`, 128: memory size in bytes; byte address width is clog2(MEM_BYTES).
- `PROT_LIMIT`, 10: write addresses below this are remapped upward by `PROT_LIMIT`.
- `Clock` in 1: single clock, all state on the rising edge.
- `ResetN` in 1: asynchronous, active-low reset.
- `Req0` / `Req1` in 1: request level, held until matching Done.
- `Write0` / `Write1` in 1: 1 = store, 0 = load; stable while Req high.
- `Addr0` / `Addr1` in 24: byte address of the word's MSB byte.
- `WData0` / `WData1` in 24: store data.
- `Done0` / `Done1` out 1: one-cycle completion pulse.
- `RData` out 24: load result, valid while Done high; shared by both ports.
- `Err` out 1: range error, valid while Done high.
- `Busy` out 1: high in every non-IDLE state.
- `MemAddr` out clog2(MEM_BYTES): byte address to memory.
- `MemWData` out 8: byte write data.
- `MemWE` out 1: byte write enable.
- `MemRData` in 8: combinational byte read data for `MemAddr`.

## Operation
- FSM states: IDLE, BYTE0, BYTE1, BYTE2, DONE.
- IDLE: if any Req is high, grant one request and latch its op, address and data.
  - Remap: a write with address < `PROT_LIMIT` has `PROT_LIMIT` added. Reads are never remapped.
  - Range check: if effective address + 2 ≥ `MEM_BYTES`, go directly to DONE with Err=1. No memory access, no wrap-around.
  - Otherwise go to BYTE0.
- BYTEk (k = 0, 1, 2): `MemAddr` = effective address + k.
  - Write: `MemWE`=1, `MemWData` = WData byte k, with byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0].
  - Read: `MemWE`=0; `MemRData` is captured into the `RData` byte lane k at the end of the cycle.
- DONE: pulse the granted port's Done; drive `RData` (reads only) and `Err`. Return to IDLE.
- Arbitration: the round-robin pointer holds the last granted port.
  - Both requesting: grant the port that is not the pointer.
  - One requesting: grant it.
  - The pointer updates only on grant. After reset the pointer = 1, so port 0 wins the first tie.
- Req is level-sensitive. A Req still high in the IDLE cycle after its Done is a new transaction. Requesters must drop Req on the edge that ends their Done cycle.
- Req changes outside IDLE are ignored; a pending request is served at the next IDLE.
- Reset values: FSM=IDLE, pointer=1; `Done0`, `Done1`, `Err`, `Busy`, `MemWE`=0; `RData`, `MemAddr`, `MemWData`=0.
- Reset mid-operation: `MemWE` drops immediately (asynchronous). A partially written word stays partially written; there is no rollback.

## Timing
- The request is seen in IDLE at cycle n. Byte accesses occur in cycles n+1, n+2, n+3. Done is high in n+4. The next grant is possible at n+5.
- Throughput: one word per 5 cycles. An error transaction takes 2 cycles (IDLE → DONE).
- All outputs are registered (Moore). `MemRData` is sampled the same cycle `MemAddr` is presented.
- `RData` holds its value until the next read completes. `Err` is 0 outside DONE.

## Structure
- Package `data_mem_pkg`:
  - state enum: IDLE, BYTE0, BYTE1, BYTE2, DONE;
  - default constants `MEM_BYTES` and `PROT_LIMIT`;
  - byte-lane offset constants.
- Sub-module `rr_arbiter2`: 2-way round-robin.
  - Inputs: req[1:0], pointer, grant-enable.
  - Outputs: one-hot grant and the next pointer value.
- All other logic (FSM, address/remap/range datapath, read assembly) lives in `data_mem_arbiter`. The block totals roughly 200 lines.

## Test plan
- Port 0 write addr 20, data 0xA1B2C3 → bytes 20/21/22 = A1/B2/C3 in cycles n+1..n+3; `Done0` at n+4, `Err`=0.
- Port 1 read addr 20 after the write above → `RData`=0xA1B2C3 with `Done1` at n+4.
- Port 0 write addr 3, data 0x112233 → bytes 13/14/15 written, bytes 3..5 untouched. A read at addr 3 then returns bytes 3..5 (no remap).
- Both Req high and held continuously from reset → grants alternate 0, 1, 0, 1; each Done arrives 5 cycles apart.
- Port 1 read addr 126 → `Err`=1 and `Done1` one cycle after IDLE; `MemWE` never asserted, `RData` unchanged.
- `ResetN` pulsed low during BYTE1 of a write → `MemWE`=0 at once and all outputs at reset values; byte 0 is written, bytes 1–2 are not. The next request is port 0 first.
